// File: rtl/mem_io_responder.sv
// Memory and IO responder: byte RAM, TX FIFO, RX pass-through, stop flag and cycle counter.
// Optional feature macro: CYCLE_COUNTER_EN adds the cycle counter and its snapshot registers.
module mem_io_responder #(
    parameter int ADDR_BITS   = 17,
    parameter int TXQ_LOG     = 3,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        prog_stop,
    output logic        tx_overflow
);

    localparam int RAM_BYTES = 2 ** ADDR_BITS;
    localparam int DEPTH     = 2 ** TXQ_LOG;
    localparam logic [TXQ_LOG:0] DEPTH_P  = DEPTH[TXQ_LOG:0];
    localparam logic [TXQ_LOG:0] MARGIN_P = FULL_MARGIN[TXQ_LOG:0];

    logic                 io_sel;
    logic [15:0]          io_off;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [7:0]           rd_data;
    logic                 unused_bits;

    logic [7:0]           ram [0:RAM_BYTES-1];

    logic [7:0]           fifo_mem [0:DEPTH-1];
    logic [TXQ_LOG:0]     wr_ptr;
    logic [TXQ_LOG:0]     rd_ptr;
    logic [TXQ_LOG:0]     wr_next;
    logic [TXQ_LOG:0]     rd_next;
    logic [TXQ_LOG:0]     count_next;
    logic [TXQ_LOG:0]     free_next;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push_req;
    logic                 push;
    logic                 pop;

    assign io_sel   = (mem_a[17:16] == 2'b11);
    assign io_off   = mem_a[15:0];
    assign ram_addr = mem_a[ADDR_BITS-1:0];

    always_ff @(posedge clk_in) begin
        if (!io_sel && mem_wr) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[TXQ_LOG] != rd_ptr[TXQ_LOG]) &&
                        (wr_ptr[TXQ_LOG-1:0] == rd_ptr[TXQ_LOG-1:0]);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_mem[rd_ptr[TXQ_LOG-1:0]];

    assign pop        = tx_valid && tx_ready;
    assign push_req   = io_sel && mem_wr && (io_off == 16'h0000) && (mem_dout != 8'h00);
    assign push       = push_req && (!fifo_full || pop);
    assign wr_next    = wr_ptr + {{TXQ_LOG{1'b0}}, push};
    assign rd_next    = rd_ptr + {{TXQ_LOG{1'b0}}, pop};
    assign count_next = wr_next - rd_next;
    assign free_next  = DEPTH_P - count_next;

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr[TXQ_LOG-1:0]] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            wr_ptr         <= wr_next;
            rd_ptr         <= rd_next;
            io_buffer_full <= (free_next <= MARGIN_P);
            if (push_req && !push) begin
                tx_overflow <= 1'b1;
            end
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_count;
    logic [31:0] snapshot;

    // Byte 0 comes live from the counter; the upper bytes come from the latch it loads.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_count <= '0;
            snapshot    <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (io_sel && !mem_wr && (io_off == 16'h0004)) begin
                snapshot <= cycle_count;
            end
        end
    end

    assign unused_bits = ^{mem_a[31:18], snapshot[7:0]};
`else
    assign unused_bits = ^mem_a[31:18];
`endif

    always_comb begin
        rd_data = 8'h00;
        if (!mem_wr) begin
            if (!io_sel) begin
                rd_data = ram[ram_addr];
            end else begin
                case (io_off)
                    16'h0000: if (rx_valid) rd_data = rx_data;
`ifdef CYCLE_COUNTER_EN
                    16'h0004: rd_data = cycle_count[7:0];
                    16'h0005: rd_data = snapshot[15:8];
                    16'h0006: rd_data = snapshot[23:16];
                    16'h0007: rd_data = snapshot[31:24];
`endif
                    default:  rd_data = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din   <= 8'h00;
            rx_pop    <= 1'b0;
            prog_stop <= 1'b0;
        end else begin
            mem_din <= rd_data;
            rx_pop  <= io_sel && !mem_wr && (io_off == 16'h0000) && rx_valid;
            if (io_sel && mem_wr && (io_off == 16'h0004)) begin
                prog_stop <= 1'b1;
            end
        end
    end

endmodule
